// File: rtl/hs_pipe_slice.sv
// hs_pipe_slice: valid/ready retiming slice with STAGES register stages on a
// single handshake channel. With SKID=1 every stage has a main and a skid
// register so the upstream ready comes straight from a flop; with SKID=0 each
// stage has a main register only and ready ripples combinationally.
module hs_pipe_slice #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 2,
  parameter int SKID       = 1,
  parameter int CNT_W      = $clog2(2 * STAGES + 1)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      occupancy
);

  // Link k is the channel entering stage k; link STAGES is the output channel.
  // lv[k+1] / ld[k+1] are the main-register valid/data of stage k.
  logic [STAGES:0]       lv;
  logic [DATA_WIDTH-1:0] ld [STAGES+1];
  logic [STAGES:0]       rdy;      // rdy[k]: stage k can accept from link k
  logic [STAGES-1:0]     s_valid;  // skid valid bits, all zero when SKID=0

  assign lv[0]     = in_valid;
  assign ld[0]     = in_data;
  assign in_ready  = rdy[0];
  assign out_valid = lv[STAGES];
  assign out_data  = ld[STAGES];

  // Ready for every link, walked from the output back towards the input.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path through the block leaves it unassigned and no latch is inferred.
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (SKID != 0) rdy[k] = ~s_valid[k];
      else           rdy[k] = ~lv[k+1] | rdy[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                  m_vld;
    logic [DATA_WIDTH-1:0] m_dat;
    logic                  accept;  // entry moves from link k into this stage
    logic                  take;    // main register moves to link k+1

    assign accept   = lv[k] & rdy[k];
    assign take     = m_vld & rdy[k+1];
    assign lv[k+1]  = m_vld;
    assign ld[k+1]  = m_dat;

    if (SKID != 0) begin : g_skid
      logic                  s_vld;
      logic [DATA_WIDTH-1:0] s_dat;

      assign s_valid[k] = s_vld;

      // Valid bits: refill main from skid (or input) on take, else park input.
      always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: sequential state is updated with non-blocking assignments so all
        // flops sample pre-edge values regardless of evaluation order.
        if (!nRST) begin
          m_vld <= 1'b0;
          s_vld <= 1'b0;
        end else if (flush) begin
          m_vld <= 1'b0;
          s_vld <= 1'b0;
        end else if (take) begin
          m_vld <= s_vld | accept;
          s_vld <= 1'b0;
        end else if (accept) begin
          if (m_vld) s_vld <= 1'b1;
          else       m_vld <= 1'b1;
        end
      end

      // Payload registers follow the same steering as the valid bits.
      always_ff @(posedge CLK) begin
        // NOTE: payload flops carry no reset; a payload is only meaningful while
        // its valid bit is set, and the valid bits are reset.
        if (take) begin
          if (s_vld)       m_dat <= s_dat;
          else if (accept) m_dat <= ld[k];
        end else if (accept) begin
          if (m_vld) s_dat <= ld[k];
          else       m_dat <= ld[k];
        end
      end

      // An occupied skid with an empty main register would break FIFO order.
      a_no_orphan_skid: assert property (@(posedge CLK) disable iff (!nRST)
        !(s_vld && !m_vld));

    end else begin : g_plain
      assign s_valid[k] = 1'b0;

      // Valid bit: load on accept, otherwise clear when taken.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)        m_vld <= 1'b0;
        else if (flush)   m_vld <= 1'b0;
        else if (accept)  m_vld <= 1'b1;
        else if (take)    m_vld <= 1'b0;
      end

      // Payload register loads whenever an entry is accepted.
      always_ff @(posedge CLK) begin
        if (accept) m_dat <= ld[k];
      end
    end
  end

  // Occupancy: popcount of every main and skid valid bit.
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + CNT_W'(lv[k+1]) + CNT_W'(s_valid[k]);
    end
  end

endmodule

// File: tb/tb_hs_pipe_slice.sv
// tb_hs_pipe_slice: four slice instances (2/skid, 3/skid, 3/plain, 1/skid)
// checked every cycle against a queue model of the channel, plus directed
// scenarios with hand-computed expectations.
module tb_hs_pipe_slice;
  localparam int N  = 4;
  localparam int DW = 8;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  logic [N-1:0]  in_valid, in_ready, out_valid, out_ready, flush;
  logic [DW-1:0] in_data [N];
  logic [DW-1:0] out_data [N];
  logic [2:0]    occ [N];
  logic [1:0]    occ_s1;

  hs_pipe_slice #(.DATA_WIDTH(DW), .STAGES(2), .SKID(1)) u_s2k (
    .CLK(CLK), .nRST(nRST), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]),
    .occupancy(occ[0]));

  hs_pipe_slice #(.DATA_WIDTH(DW), .STAGES(3), .SKID(1)) u_s3k (
    .CLK(CLK), .nRST(nRST), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]),
    .occupancy(occ[1]));

  hs_pipe_slice #(.DATA_WIDTH(DW), .STAGES(3), .SKID(0)) u_s3p (
    .CLK(CLK), .nRST(nRST), .flush(flush[2]),
    .in_valid(in_valid[2]), .in_data(in_data[2]), .in_ready(in_ready[2]),
    .out_valid(out_valid[2]), .out_data(out_data[2]), .out_ready(out_ready[2]),
    .occupancy(occ[2]));

  hs_pipe_slice #(.DATA_WIDTH(DW), .STAGES(1), .SKID(1)) u_s1k (
    .CLK(CLK), .nRST(nRST), .flush(flush[3]),
    .in_valid(in_valid[3]), .in_data(in_data[3]), .in_ready(in_ready[3]),
    .out_valid(out_valid[3]), .out_data(out_data[3]), .out_ready(out_ready[3]),
    .occupancy(occ_s1));

  assign occ[3] = {1'b0, occ_s1};

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mq [N][$];  // model: entries each slice holds, head first

  function automatic int cap_of(input int d);
    case (d)
      0:       return 4;
      1:       return 6;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit skid_of(input int d);
    return d != 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the queue model; the model then advances by
  // the handshakes that will complete at the coming rising edge.
  always @(negedge CLK) begin
    if (!nRST) begin
      for (int d = 0; d < N; d++) mq[d].delete();
    end else begin
      for (int d = 0; d < N; d++) begin
        check($sformatf("occupancy[%0d]", d), 32'(occ[d]), 32'(mq[d].size()));
        check($sformatf("occ_bound[%0d]", d), 32'(int'(occ[d]) <= cap_of(d)), 1);
        if (mq[d].size() == 0) begin
          check($sformatf("empty_out_valid[%0d]", d), 32'(out_valid[d]), 0);
          check($sformatf("empty_in_ready[%0d]", d), 32'(in_ready[d]), 1);
        end
        if (skid_of(d) && mq[d].size() == cap_of(d))
          check($sformatf("full_in_ready[%0d]", d), 32'(in_ready[d]), 0);
        if (!skid_of(d))
          check($sformatf("plain_in_ready[%0d]", d), 32'(in_ready[d]),
                32'((mq[d].size() < cap_of(d)) || out_ready[d]));
        if (out_valid[d] && out_ready[d]) begin
          check($sformatf("pop_nonempty[%0d]", d), 32'(mq[d].size() != 0), 1);
          if (mq[d].size() != 0) begin
            check($sformatf("pop_data[%0d]", d), 32'(out_data[d]), 32'(mq[d][0]));
            void'(mq[d].pop_front());
          end
        end
        if (in_valid[d] && in_ready[d]) mq[d].push_back(in_data[d]);
        if (flush[d]) mq[d].delete();
      end
    end
  end

  task automatic idle();
    in_valid  = '0;
    out_ready = '1;
    flush     = '0;
  endtask

  // 16 back-to-back pushes on the 2-stage skid slice: latency 2, no bubbles.
  task automatic t_stream();
    int got = 0;
    for (int c = 0; c < 24; c++) begin
      @(posedge CLK); #1;
      in_valid[0]  = (c < 16);
      in_data[0]   = 8'(c + 1);
      out_ready[0] = 1'b1;
      @(negedge CLK);
      check("stream_in_ready", 32'(in_ready[0]), 1);
      if (out_valid[0]) begin
        check("stream_data", 32'(out_data[0]), 32'(got + 1));
        check("stream_cycle", 32'(c), 32'(got + 2));
        got++;
      end
    end
    check("stream_count", 32'(got), 16);
    idle();
  endtask

  // Push into a stalled 2-stage skid slice, then drain.
  task automatic t_fill();
    int acc = 0;
    int got = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge CLK); #1;
      in_valid[0]  = 1'b1;
      in_data[0]   = 8'(acc + 1);
      out_ready[0] = 1'b0;
      @(negedge CLK);
      if (in_valid[0] && in_ready[0]) acc++;
    end
    check("fill_accepts", 32'(acc), 4);
    check("fill_in_ready", 32'(in_ready[0]), 0);
    check("fill_occupancy", 32'(occ[0]), 4);
    for (int c = 0; c < 12; c++) begin
      @(posedge CLK); #1;
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      @(negedge CLK);
      if (out_valid[0]) begin
        check("drain_data", 32'(out_data[0]), 32'(got + 1));
        got++;
      end
    end
    check("drain_count", 32'(got), 4);
    idle();
  endtask

  // Three entries held, then flush together with a push and a pop.
  task automatic t_flush();
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      in_valid[0]  = 1'b1;
      in_data[0]   = 8'(8'h11 * (i + 1));
      out_ready[0] = 1'b0;
      @(negedge CLK);
      check("flush_fill_ready", 32'(in_ready[0]), 1);
    end
    @(posedge CLK); #1;
    flush[0]     = 1'b1;
    in_valid[0]  = 1'b1;
    in_data[0]   = 8'hAA;
    out_ready[0] = 1'b1;
    @(negedge CLK);
    check("flush_head_valid", 32'(out_valid[0]), 1);
    check("flush_head_data", 32'(out_data[0]), 32'h11);
    check("flush_in_ready", 32'(in_ready[0]), 1);
    @(posedge CLK); #1;
    flush[0]    = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge CLK);
    check("post_flush_occ", 32'(occ[0]), 0);
    check("post_flush_valid", 32'(out_valid[0]), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      check("post_flush_quiet", 32'(out_valid[0]), 0);
    end
    idle();
  endtask

  // Asynchronous reset pulse between edges with two entries held.
  task automatic t_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      in_valid[0]  = 1'b1;
      in_data[0]   = 8'(8'h70 + i);
      out_ready[0] = 1'b0;
    end
    @(negedge CLK);
    @(posedge CLK); #1;
    in_valid[0] = 1'b0;
    check("rst_pre_occ", 32'(occ[0]), 2);
    #1 nRST = 1'b0;
    #1;
    for (int d = 0; d < N; d++) begin
      check($sformatf("rst_out_valid[%0d]", d), 32'(out_valid[d]), 0);
      check($sformatf("rst_in_ready[%0d]", d), 32'(in_ready[d]), 1);
      check($sformatf("rst_occ[%0d]", d), 32'(occ[d]), 0);
    end
    #4 nRST = 1'b1;
    idle();
    t_stream();
  endtask

  // Random valid/ready on both 3-stage slices until 1000 entries pass each.
  task automatic t_random();
    int acc [3];
    int del [3];
    int cyc = 0;
    for (int d = 1; d < 3; d++) begin
      acc[d] = 0;
      del[d] = 0;
    end
    while ((del[1] < 1000 || del[2] < 1000) && cyc < 9000) begin
      @(posedge CLK); #1;
      for (int d = 1; d < 3; d++) begin
        in_valid[d]  = (acc[d] < 1000) ? 1'($urandom_range(1, 0)) : 1'b0;
        in_data[d]   = 8'($urandom);
        out_ready[d] = 1'($urandom_range(1, 0));
      end
      @(negedge CLK);
      for (int d = 1; d < 3; d++) begin
        if (in_valid[d] && in_ready[d]) acc[d]++;
        if (out_valid[d] && out_ready[d]) del[d]++;
      end
      cyc++;
    end
    for (int d = 1; d < 3; d++) begin
      check($sformatf("rand_accepted[%0d]", d), 32'(acc[d]), 1000);
      check($sformatf("rand_delivered[%0d]", d), 32'(del[d]), 1000);
    end
    idle();
  endtask

  // Single-stage skid slice: capacity 2, pop plus push keeps one entry.
  task automatic t_single();
    int acc = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      in_valid[3]  = 1'b1;
      in_data[3]   = 8'(8'h50 + acc);
      out_ready[3] = 1'b0;
      @(negedge CLK);
      if (in_valid[3] && in_ready[3]) acc++;
    end
    check("s1_accepts", 32'(acc), 2);
    check("s1_in_ready", 32'(in_ready[3]), 0);
    check("s1_occ_full", 32'(occ[3]), 2);
    @(posedge CLK); #1;
    in_valid[3]  = 1'b0;
    out_ready[3] = 1'b1;
    @(negedge CLK);
    check("s1_head", 32'(out_data[3]), 32'h50);
    @(posedge CLK); #1;
    in_valid[3]  = 1'b1;
    in_data[3]   = 8'h60;
    out_ready[3] = 1'b1;
    @(negedge CLK);
    check("s1_pushpop_occ", 32'(occ[3]), 1);
    check("s1_pushpop_ready", 32'(in_ready[3]), 1);
    check("s1_pushpop_data", 32'(out_data[3]), 32'h51);
    @(posedge CLK); #1;
    in_valid[3]  = 1'b0;
    out_ready[3] = 1'b0;
    @(negedge CLK);
    check("s1_after_occ", 32'(occ[3]), 1);
    check("s1_after_valid", 32'(out_valid[3]), 1);
    check("s1_after_data", 32'(out_data[3]), 32'h60);
    idle();
    repeat (3) @(posedge CLK);
  endtask

  initial begin
    nRST = 1'b0;
    idle();
    for (int d = 0; d < N; d++) in_data[d] = '0;
    repeat (2) @(posedge CLK);
    #2;
    for (int d = 0; d < N; d++) begin
      check($sformatf("reset_in_ready[%0d]", d), 32'(in_ready[d]), 1);
      check($sformatf("reset_out_valid[%0d]", d), 32'(out_valid[d]), 0);
      check($sformatf("reset_occ[%0d]", d), 32'(occ[d]), 0);
    end
    @(negedge CLK);
    nRST = 1'b1;

    t_stream();
    t_fill();
    t_flush();
    t_reset();
    t_random();
    t_single();

    repeat (2) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
